// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - register map, bit positions and FSM encoding for the MMIO UART
package uart_mmio_pkg;

    // Byte offsets from BASE_ADDR; only ADDR[3:2] selects the register.
    localparam logic [31:0] OFS_TXDATA = 32'h0000_0000;
    localparam logic [31:0] OFS_STATUS = 32'h0000_0004;
    localparam logic [31:0] OFS_CTRL   = 32'h0000_0008;

    // STATUS bit positions; the FIFO level field starts at ST_LEVEL_LSB.
    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVF       = 3;
    localparam int ST_LEVEL_LSB = 8;

    // CTRL bit positions; flush and clear-overflow are strobes that read 0.
    localparam int CTRL_ENABLE  = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_CLR_OVF = 2;

    // Transmit FSM encoding.
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Word index of a register inside the 3-word window.
    function automatic logic [1:0] reg_index(input logic [31:0] ofs);
        return ofs[3:2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - byte FIFO with push/pop/flush and level output
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, din         write request and data; taken when not full, or when full and popping
//   pop, dout         read request; dout shows the head entry (valid while !empty)
//   flush             clears the FIFO next edge, overriding push and pop
//   full, empty       occupancy flags
//   level             number of stored entries, 0 .. 2**AW
module sync_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    input  logic          flush,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (level == '0);
    // level never exceeds DEPTH, so its MSB alone marks full.
    assign full    = level[AW];
    assign pop_ok  = pop & ~flush & ~empty;
    assign push_ok = push & ~flush & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO
// Ports:
//   CLK             system clock, rising edge
//   Reset           asynchronous active-low reset
//   ADDR            byte address from cpu
//   Data_BUS_WRITE  write data from cpu
//   CS, WE          chip select, write enable (1 = write)
//   Data_BUS_READ   read data, 0 when not selected for a read
//   SEL             combinational window hit for the bus read mux
//   TX              serial line, idle high
//   IRQ             level: FIFO empty and transmitter idle while enabled
module uart_tx_mmio
    import uart_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          FIFO_AW      = 3
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] ADDR,
    input  logic [31:0] Data_BUS_WRITE,
    input  logic        CS,
    input  logic        WE,
    output logic [31:0] Data_BUS_READ,
    output logic        SEL,
    output logic        TX,
    output logic        IRQ
);

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

    logic [31:0]       ofs;
    logic [1:0]        ridx;
    logic              in_window;
    logic              wr_txdata;
    logic              wr_ctrl;
    logic              flush;
    logic              clr_ovf;

    logic [1:0]        state;
    logic [15:0]       baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              enable;
    logic              overflow;
    logic              irq_q;
    logic              bit_end;
    logic              pop;
    logic              busy;

    logic [7:0]        fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FIFO_AW:0]  fifo_level;
    logic [31:0]       rdata;
    logic              unused_bits;

    // Address decode: three consecutive words starting at BASE_ADDR.
    assign ofs       = ADDR - BASE_ADDR;
    assign ridx      = reg_index(ofs);
    assign in_window = (ofs[31:4] == 28'd0) && (ridx != 2'b11);
    assign SEL       = CS & in_window;

    assign wr_txdata = SEL & WE & (ridx == reg_index(OFS_TXDATA));
    assign wr_ctrl   = SEL & WE & (ridx == reg_index(OFS_CTRL));
    assign flush     = wr_ctrl & Data_BUS_WRITE[CTRL_FLUSH];
    assign clr_ovf   = wr_ctrl & Data_BUS_WRITE[CTRL_CLR_OVF];

    assign bit_end   = (baud_cnt == 16'd0);
    assign busy      = (state != S_IDLE);
    // A byte is taken from the FIFO either from idle or at the very end of a
    // stop bit, which is what makes consecutive frames gap-free. A flush in
    // the same cycle discards the head byte instead of sending it.
    assign pop = enable & ~fifo_empty & ~flush &
                 ((state == S_IDLE) | ((state == S_STOP) & bit_end));

    sync_fifo #(
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (Reset),
        .push  (wr_txdata),
        .din   (Data_BUS_WRITE[7:0]),
        .pop   (pop),
        .flush (flush),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state    <= S_IDLE;
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            shift    <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shift    <= fifo_dout;
                        baud_cnt <= BAUD_MAX;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_MAX;
                        bit_idx  <= 3'd0;
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= BAUD_MAX;
                        shift    <= shift >> 1;
                        bit_idx  <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    if (bit_end) begin
                        if (pop) begin
                            shift    <= fifo_dout;
                            baud_cnt <= BAUD_MAX;
                            state    <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            enable   <= 1'b1;
            overflow <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl) begin
                enable <= Data_BUS_WRITE[CTRL_ENABLE];
            end
            // A push into a full FIFO is only lost when no pop frees a slot.
            if (clr_ovf) begin
                overflow <= 1'b0;
            end else if (wr_txdata & fifo_full & ~pop) begin
                overflow <= 1'b1;
            end
            irq_q <= enable & fifo_empty & ~busy;
        end
    end

    // Line driven straight from state so reset forces it high immediately.
    assign TX  = (state == S_START) ? 1'b0 :
                 (state == S_DATA)  ? shift[0] : 1'b1;
    assign IRQ = irq_q;

    always_comb begin
        rdata = 32'd0;
        if (ridx == reg_index(OFS_STATUS)) begin
            rdata[ST_BUSY]                       = busy;
            rdata[ST_FULL]                       = fifo_full;
            rdata[ST_EMPTY]                      = fifo_empty;
            rdata[ST_OVF]                        = overflow;
            rdata[ST_LEVEL_LSB +: FIFO_AW + 1]   = fifo_level;
        end else if (ridx == reg_index(OFS_CTRL)) begin
            rdata[CTRL_ENABLE] = enable;
        end
    end

    assign Data_BUS_READ = (SEL & ~WE) ? rdata : 32'd0;

    assign unused_bits = &{1'b0, Data_BUS_WRITE[31:8], Data_BUS_WRITE[7:3], ofs[1:0]};

endmodule
